// File: rtl/pdm_mic_rx_if.sv
// Port bundle for the PDM microphone receiver: mic pins, capture enable,
// and the PCM valid/ready output channel.
interface pdm_mic_rx_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             mic_data;
    logic             mic_clk;
    logic             mic_lrsel;
    logic [WIDTH-1:0] pcm_data;
    logic             pcm_valid;
    logic             pcm_ready;
    logic             overrun;
    logic             active;

    modport master (
        input  en,
        input  mic_data,
        input  pcm_ready,
        output mic_clk,
        output mic_lrsel,
        output pcm_data,
        output pcm_valid,
        output overrun,
        output active
    );

    modport slave (
        output en,
        output mic_data,
        output pcm_ready,
        input  mic_clk,
        input  mic_lrsel,
        input  pcm_data,
        input  pcm_valid,
        input  overrun,
        input  active
    );
endinterface

// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: generates mic_clk, counts ones per DECIM-bit window.
// Define PDM_SIGNED_EN for two's-complement PCM output (MSB inverted).
module pdm_mic_rx #(
    parameter int FI     = 100000000,
    parameter int FS     = 2000000,
    parameter int DECIM  = 128,
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         reset,
    pdm_mic_rx_if.master bus
);
    localparam int HALF = FI / (2 * FS);
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int CW   = $clog2(DECIM + 1);
    localparam int AW   = (CW > WIDTH) ? CW : WIDTH + 1;
    localparam int SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [DW-1:0]    DIV_LAST = DW'(HALF - 1);
    localparam logic [AW-1:0]    CNT_LAST = AW'(DECIM - 1);
    localparam logic [WIDTH-1:0] SAT_W    = '1;
    localparam logic [WIDTH-1:0] MSB_W    = WIDTH'(1) << (WIDTH - 1);

    if (HALF < 2 || (FI % (2 * FS)) != 0) begin : g_bad_div
        $error("pdm_mic_rx: FI/(2*FS) must be an integer >= 2");
    end
    if (DECIM < 2 || DECIM > (1 << WIDTH)) begin : g_bad_decim
        $error("pdm_mic_rx: DECIM must lie in 2..2**WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic             mclk_q, mclk_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [SW-1:0]    set_q, set_d;
    logic [1:0]       sync_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic             tick;
    logic             smp;
    logic             win_done;
    logic             load;
    logic [AW-1:0]    ones_w;
    logic [WIDTH-1:0] res_w;
    logic [WIDTH-1:0] pcm_w;

    // The sampled bit is counted into the window it closes.
    assign ones_w = acc_q + AW'(sync_q[1]);
    assign res_w  = (ones_w > AW'(SAT_W)) ? SAT_W : ones_w[WIDTH-1:0];

`ifdef PDM_SIGNED_EN
    assign pcm_w = res_w ^ MSB_W;
`else
    assign pcm_w = res_w;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.mic_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            mclk_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            set_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            mclk_q  <= mclk_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            set_q   <= set_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        mclk_d   = mclk_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        set_d    = set_q;
        tick     = 1'b0;
        smp      = 1'b0;
        win_done = 1'b0;
        if (!bus.en) begin
            state_d = S_IDLE;
            div_d   = '0;
            mclk_d  = 1'b0;
            cnt_d   = '0;
            acc_d   = '0;
            set_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = (SETTLE == 0) ? S_RUN : S_SETTLE;
                    div_d   = '0;
                    mclk_d  = 1'b0;
                    cnt_d   = '0;
                    acc_d   = '0;
                    set_d   = '0;
                end
                default: begin
                    tick  = (div_q == DIV_LAST);
                    div_d = tick ? '0 : div_q + 1'b1;
                    if (tick) begin
                        mclk_d = ~mclk_q;
                    end
                    // Sample on the falling toggle of mic_clk.
                    smp = tick && mclk_q;
                    if (smp) begin
                        win_done = (cnt_q == CNT_LAST);
                        cnt_d    = win_done ? '0 : cnt_q + 1'b1;
                        acc_d    = win_done ? '0 : ones_w;
                    end
                    if (win_done && state_q == S_SETTLE) begin
                        if (set_q == SW'(SETTLE - 1)) begin
                            state_d = S_RUN;
                            set_d   = '0;
                        end else begin
                            set_d = set_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign load = win_done && (state_q == S_RUN);

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (load) begin
            data_d  = pcm_w;
            valid_d = 1'b1;
            if (valid_q && !bus.pcm_ready) begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && bus.pcm_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.mic_clk   = mclk_q;
    assign bus.mic_lrsel = 1'b0;
    assign bus.pcm_data  = data_q;
    assign bus.pcm_valid = valid_q;
    assign bus.overrun   = ovr_q;
    assign bus.active    = (state_q == S_RUN);
endmodule

// File: tb/tb_pdm_mic_rx.sv
// Scoreboard bench for pdm_mic_rx: random PDM streams vs a window-count model.
module tb_pdm_mic_rx;
    localparam int FI     = 100000000;
    localparam int FS     = 10000000;
    localparam int DECIM  = 16;
    localparam int WIDTH  = 4;
    localparam int SETTLE = 2;
    localparam int HALF   = FI / (2 * FS);
    localparam int WIN    = 2 * HALF * DECIM;
    localparam int LIM    = 4 * WIN;

    logic clk = 1'b0;
    logic reset = 1'b1;

    pdm_mic_rx_if #(.WIDTH(WIDTH)) bus ();

    pdm_mic_rx #(
        .FI(FI), .FS(FS), .DECIM(DECIM),
        .WIDTH(WIDTH), .SETTLE(SETTLE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int sb_q[$];
    int m_bits, m_ones, m_win;
    int n_pop = 0;
    int last_exp = 0;
    int mode = 1;
    int dens = 50;
    bit alt = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    function automatic void model_clear();
        m_bits = 0;
        m_ones = 0;
        m_win  = 0;
    endfunction

    function automatic int exp_pcm(input int ones);
        int s;
        s = (ones > (1 << WIDTH) - 1) ? (1 << WIDTH) - 1 : ones;
`ifdef PDM_SIGNED_EN
        s = s ^ (1 << (WIDTH - 1));
`endif
        return s;
    endfunction

    // Every DECIM bits form a window; the first SETTLE windows per session are dropped.
    function automatic void model_bit(input bit b);
        m_bits++;
        m_ones += int'(b);
        if (m_bits == DECIM) begin
            if (m_win >= SETTLE) sb_q.push_back(exp_pcm(m_ones));
            m_win++;
            m_bits = 0;
            m_ones = 0;
        end
    endfunction

    // Mic model: new bit after each mic_clk rise, read by the receiver at the fall.
    initial begin
        bit b;
        bus.mic_data = 1'b0;
        forever begin
            @(posedge bus.mic_clk);
            #1;
            case (mode)
                0: b = ($urandom_range(0, 99) < dens);
                1: b = 1'b1;
                2: begin alt = ~alt; b = alt; end
                default: b = 1'b0;
            endcase
            bus.mic_data = b;
            model_bit(b);
        end
    end

    always @(negedge clk) begin
        if (reset && bus.pcm_valid && bus.pcm_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_sample: got %0d, expected none (t=%0t)",
                         bus.pcm_data, $time);
            end else begin
                last_exp = sb_q.pop_front();
                check("pcm_data", int'(bus.pcm_data), last_exp);
            end
            n_pop++;
        end
    end

    task automatic wait_pops(input int k);
        int target;
        int c;
        target = n_pop + k;
        c = 0;
        while (n_pop < target && c < k * LIM) begin
            @(posedge clk);
            c++;
        end
        if (n_pop < target) timeout("wait_pops");
    endtask

    task automatic wait_sb(input int k);
        int c;
        c = 0;
        while (sb_q.size() < k && c < LIM) begin
            @(posedge clk);
            #2;
            c++;
        end
        if (sb_q.size() < k) timeout("wait_sb");
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_mic_clk"}, int'(bus.mic_clk), 0);
        check({nm, "_lrsel"}, int'(bus.mic_lrsel), 0);
        check({nm, "_pcm_data"}, int'(bus.pcm_data), 0);
        check({nm, "_pcm_valid"}, int'(bus.pcm_valid), 0);
        check({nm, "_overrun"}, int'(bus.overrun), 0);
        check({nm, "_active"}, int'(bus.active), 0);
    endtask

    initial begin
        int n;
        bus.en = 1'b0;
        bus.pcm_ready = 1'b0;
        model_clear();
        #1 reset = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // Clock generation and all-ones saturation.
        mode = 1;
        bus.pcm_ready = 1'b1;
        @(negedge clk) bus.en = 1'b1;
        @(posedge clk);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.mic_clk && n < 100);
        check("first_rise", n, HALF);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (bus.mic_clk && n < 100);
        check("high_time", n, HALF);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.mic_clk && n < 100);
        check("low_time", n, HALF);
        check("lrsel", int'(bus.mic_lrsel), 0);
        check("active_settle", int'(bus.active), 0);
        wait_pops(1);
        check("active_run", int'(bus.active), 1);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.pcm_valid && n < LIM);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.pcm_valid && n < LIM);
        check("valid_period", n, WIN);
        wait_pops(1);

        // Alternating, random-density and all-zero streams.
        mode = 2;
        wait_pops(3);
        mode = 0;
        for (int i = 0; i < 8; i++) begin
            dens = $urandom_range(0, 100);
            wait_pops(1);
        end
        mode = 3;
        wait_pops(2);
        mode = 0;
        dens = 50;

        // Two loads without a handshake: second overwrites first.
        @(negedge clk) bus.pcm_ready = 1'b0;
        wait_sb(1);
        repeat (6) @(posedge clk);
        #1;
        check("ovr_first_valid", int'(bus.pcm_valid), 1);
        check("ovr_before", int'(bus.overrun), 0);
        repeat (20) @(posedge clk);
        #1 check("hold_stable", int'(bus.pcm_data), sb_q.size() > 0 ? sb_q[0] : -1);
        wait_sb(2);
        repeat (6) @(posedge clk);
        #1;
        check("ovr_set", int'(bus.overrun), 1);
        check("ovr_data", int'(bus.pcm_data), sb_q.size() > 1 ? sb_q[1] : -1);
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        @(negedge clk) bus.pcm_ready = 1'b1;
        wait_pops(1);
        check("ovr_sticky", int'(bus.overrun), 1);

        // Asynchronous reset with a sample pending.
        @(negedge clk) bus.pcm_ready = 1'b0;
        n = 0;
        while (!bus.pcm_valid && n < LIM) begin @(negedge clk); n++; end
        check("pre_reset_valid", int'(bus.pcm_valid), 1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_rst");
        sb_q.delete();
        model_clear();
        @(negedge clk) reset = 1'b1;

        // Handshake in the same cycle as a load leaves overrun clear.
        wait_sb(2);
        repeat (4) @(posedge clk);
        #1 bus.pcm_ready = 1'b1;
        @(posedge clk);
        #1;
        check("same_cycle_ovr", int'(bus.overrun), 0);
        check("same_cycle_valid", int'(bus.pcm_valid), 1);
        check("same_cycle_data", int'(bus.pcm_data), sb_q.size() > 0 ? sb_q[0] : -1);
        wait_pops(2);

        // Enable dropped mid-window, then restart through settle.
        repeat ($urandom_range(30, 100)) @(posedge clk);
        check("q_empty_at_drop", sb_q.size(), 0);
        @(negedge clk) bus.en = 1'b0;
        @(posedge clk);
        #1;
        check("en_off_mic_clk", int'(bus.mic_clk), 0);
        check("en_off_active", int'(bus.active), 0);
        check("en_off_data_kept", int'(bus.pcm_data), last_exp);
        repeat (10) @(posedge clk);
        model_clear();
        @(negedge clk) bus.en = 1'b1;
        repeat (300) @(posedge clk);
        #1 check("resettle_active", int'(bus.active), 0);
        wait_pops(3);

        n = 0;
        while (sb_q.size() > 0 && n < LIM) begin @(posedge clk); n++; end
        check("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pdm_mic_rx.md
PDM_MIC_RX -- requirements
Module: pdm_mic_rx

Interface
REQ-001 Parameter FI, default 100000000, system clock frequency in Hz.
REQ-002 Parameter FS, default 2000000, microphone clock frequency in Hz; FI/(2*FS) SHALL be an integer >= 2.
REQ-003 Parameter DECIM, default 128, number of PDM bits per PCM sample; range 2..2^WIDTH.
REQ-004 Parameter WIDTH, default 8, PCM sample width in bits.
REQ-005 Parameter SETTLE, default 2, number of initial windows discarded after enable.
REQ-006 Port clk  input  1  system clock; all logic on rising edge.
REQ-007 Port reset  input  1  asynchronous, active-low reset.
REQ-008 Port en  input  1  capture enable; low SHALL force IDLE.
REQ-009 Port mic_data  input  1  PDM bit from microphone, asynchronous to clk.
REQ-010 Port mic_clk  output  1  generated microphone clock.
REQ-011 Port mic_lrsel  output  1  channel select, constant 0.
REQ-012 Port pcm_data  output  WIDTH  PCM sample.
REQ-013 Port pcm_valid  output  1  pcm_data holds an unconsumed sample.
REQ-014 Port pcm_ready  input  1  consumer accepts a sample when pcm_valid and pcm_ready are both high.
REQ-015 Port overrun  output  1  sticky flag: an unconsumed sample was overwritten.
REQ-016 Port active  output  1  high in RUN state.

Function
REQ-017 States IDLE, SETTLE, RUN; IDLE->SETTLE when en=1; SETTLE->RUN after SETTLE complete windows; any state->IDLE within one cycle of en=0.
REQ-018 In IDLE: mic_clk=0, divider count, bit counter and ones accumulator cleared; pcm_data, pcm_valid and overrun keep their values.
REQ-019 Outside IDLE, mic_clk SHALL toggle every FI/(2*FS) clk cycles, giving exactly FS; the first rising edge SHALL come FI/(2*FS) cycles after leaving IDLE.
REQ-020 mic_data SHALL pass through a two-flop synchronizer before use.
REQ-021 The synchronized bit SHALL be sampled on the clk cycle in which mic_clk toggles 1->0; each sample increments the bit counter and, when 1, the ones accumulator.
REQ-022 Window completes at the DECIM-th sample; bit counter and accumulator SHALL restart from 0, counting the completing sample in the closed window, with no lost bits.
REQ-023 Window result = ones count, saturated to 2^WIDTH-1 when count = 2^WIDTH.
REQ-024 In SETTLE, completed windows SHALL be discarded without touching pcm_data or pcm_valid.
REQ-025 In RUN, a completed window SHALL load pcm_data and set pcm_valid on the next cycle; latency is 1 clk from the completing sample.
REQ-026 pcm_valid SHALL clear the cycle after a handshake unless a new sample loads in that same cycle; then pcm_valid stays 1 with the new data and overrun is not set.
REQ-027 If a sample loads while pcm_valid=1 and pcm_ready=0, pcm_data SHALL be overwritten and overrun set; overrun clears only on reset.
REQ-028 pcm_data SHALL stay stable while pcm_valid=1 and no new sample loads.

Reset
REQ-029 While reset=0: state IDLE, mic_clk=0, mic_lrsel=0, pcm_data=0, pcm_valid=0, overrun=0, active=0, all counters and synchronizer flops 0.
REQ-030 Reset asserted mid-window SHALL abandon the partial window; after release, capture restarts via SETTLE.

Configuration
REQ-031 Macro PDM_SIGNED_EN: when defined, pcm_data SHALL be the saturated result with the MSB inverted (two's complement, midscale = 0); when undefined, pcm_data SHALL be unsigned offset binary.

Verification
REQ-032 Defaults, en=1 -> mic_clk period 50 clk, 50 % duty; first rise 25 cycles after leaving IDLE; mic_lrsel=0.
REQ-033 Defaults, mic_data constant 1, pcm_ready=1 -> no pcm_valid for the first 2 windows (12800 clk); then pcm_valid pulses every 6400 clk with pcm_data=128 (0x00 with PDM_SIGNED_EN).
REQ-034 DECIM=256, WIDTH=8, mic_data=1 -> pcm_data=255 (saturated); mic_data alternating 1/0 -> pcm_data=128.
REQ-035 pcm_ready=0 across two completed RUN windows -> second sample overwrites the first, overrun=1; asserting pcm_ready in the same cycle as the load leaves overrun=0.
REQ-036 en dropped mid-window -> mic_clk=0 within 1 clk, active=0; after en returns, 2 windows are discarded before the next pcm_valid.
REQ-037 reset pulsed low during RUN with pcm_valid=1 -> all outputs at REQ-029 values asynchronously, before the next clk edge.
